// File: rtl/clock_display_sequencer.sv
// Scans an "HH:MM:SS" time string across a band of video lines, producing a
// glyph index and bitmap bit index per pixel for a downstream glyph ROM.
module clock_display_sequencer #(
  parameter int unsigned BOX_SIZE  = 10,
  parameter int unsigned START_ROW = 35
) (
  input  logic        pixelclock,
  input  logic        resetn,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic        draw,
  input  logic [23:0] time_bcd,
  output logic [3:0]  glyph_sel,
  output logic [3:0]  bit_index,
  output logic        pixel_valid,
  output logic        busy
);

  localparam int unsigned LINE_W = 10;
  localparam int unsigned CMP_W  = 11;
  localparam int unsigned REP_W  = 4;

  localparam logic [LINE_W-1:0] LINE_MAX = '1;
  localparam logic [CMP_W-1:0]  BAND_LO  = CMP_W'(START_ROW);
  localparam logic [CMP_W-1:0]  BAND_HI  = CMP_W'(START_ROW + 5 * BOX_SIZE - 1);
  localparam logic [REP_W-1:0]  REP_MAX  = REP_W'(BOX_SIZE - 1);
  localparam logic [3:0]        GLYPH_COLON = 4'd10;
  localparam logic [3:0]        GLYPH_BLANK = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [REP_W-1:0]    v_rep_q;
  logic [2:0]          row_q;
  logic [REP_W-1:0]    h_rep_q;
  logic [1:0]          col_q;
  logic [2:0]          char_q;
  logic [23:0]         shadow_q;
  logic                frame_seen_q;
  logic [3:0]          glyph_sel_q;
  logic [3:0]          bit_index_q;
  logic                pixel_valid_q;
  logic                busy_q;

  logic                next_in_band_c;
  logic                band_first_c;
  logic                pix_c;
  logic                last_pix_c;
  logic [3:0]          digit_c;
  logic [3:0]          glyph_c;
  logic [3:0]          bit_c;

  // Line counter next value and band membership of the line about to start
  always_comb begin
    line_d = line_q;
    if (frame_start) begin
      line_d = '0;
    end else if (line_start && (line_q != LINE_MAX)) begin
      line_d = line_q + 10'd1;
    end
    next_in_band_c = line_start && !frame_start &&
                     ({1'b0, line_d} >= BAND_LO) && ({1'b0, line_d} <= BAND_HI);
    band_first_c   = next_in_band_c && ({1'b0, line_d} == BAND_LO);
  end

  // Current pixel decode: character digit, glyph and bitmap index
  always_comb begin
    pix_c      = !frame_start && draw && ((state_q == ARMED) || (state_q == SCAN));
    last_pix_c = (char_q == 3'd7) && (col_q == 2'd3) && (h_rep_q == REP_MAX);
    case (char_q)
      3'd0:    digit_c = shadow_q[23:20];
      3'd1:    digit_c = shadow_q[19:16];
      3'd3:    digit_c = shadow_q[15:12];
      3'd4:    digit_c = shadow_q[11:8];
      3'd6:    digit_c = shadow_q[7:4];
      3'd7:    digit_c = shadow_q[3:0];
      default: digit_c = 4'd0;
    endcase
    if ((char_q == 3'd2) || (char_q == 3'd5)) begin
      glyph_c = GLYPH_COLON;
    end else if (digit_c > 4'd9) begin
      glyph_c = GLYPH_BLANK;
    end else begin
      glyph_c = digit_c;
    end
    bit_c = 4'(row_q) * 4'd3 + 4'(col_q);
  end

  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (next_in_band_c && frame_seen_q) state_d = ARMED;
        ARMED: begin
          if (draw) begin
            state_d = SCAN;
          end else if (line_start && !next_in_band_c) begin
            state_d = IDLE;
          end
        end
        SCAN:    if (!draw || last_pix_c) state_d = DONE;
        DONE:    if (line_start) state_d = next_in_band_c ? ARMED : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge pixelclock) begin
    if (!resetn) begin
      state_q       <= IDLE;
      line_q        <= '0;
      v_rep_q       <= '0;
      row_q         <= '0;
      h_rep_q       <= '0;
      col_q         <= '0;
      char_q        <= '0;
      shadow_q      <= '0;
      frame_seen_q  <= 1'b0;
      glyph_sel_q   <= '0;
      bit_index_q   <= '0;
      pixel_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == SCAN);
      line_q  <= line_d;

      // Vertical glyph row tracking: BOX_SIZE lines per glyph row
      if (frame_start) begin
        shadow_q     <= time_bcd;
        frame_seen_q <= 1'b1;
        v_rep_q      <= '0;
        row_q        <= '0;
      end else if (band_first_c) begin
        v_rep_q <= '0;
        row_q   <= '0;
      end else if (next_in_band_c) begin
        if (v_rep_q == REP_MAX) begin
          v_rep_q <= '0;
          row_q   <= row_q + 3'd1;
        end else begin
          v_rep_q <= v_rep_q + 4'd1;
        end
      end

      // Horizontal position; counters sit at zero whenever no pixel is scanned
      if (pix_c) begin
        if (h_rep_q == REP_MAX) begin
          h_rep_q <= '0;
          col_q   <= col_q + 2'd1;
          if (col_q == 2'd3) begin
            char_q <= char_q + 3'd1;
          end
        end else begin
          h_rep_q <= h_rep_q + 4'd1;
        end
      end else begin
        h_rep_q <= '0;
        col_q   <= '0;
        char_q  <= '0;
      end

      pixel_valid_q <= 1'b0;
      if (pix_c && (col_q != 2'd3) && (glyph_c != GLYPH_BLANK)) begin
        pixel_valid_q <= 1'b1;
        glyph_sel_q   <= glyph_c;
        bit_index_q   <= bit_c;
      end
    end
  end

  assign glyph_sel   = glyph_sel_q;
  assign bit_index   = bit_index_q;
  assign pixel_valid = pixel_valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_clock_display_sequencer.sv
// Self-checking bench for clock_display_sequencer: randomized time values and
// draw windows compared against a per-pixel arithmetic model of the display.
module tb_clock_display_sequencer;

  localparam int B     = 10;
  localparam int START = 35;
  localparam int SCAN_W = 32 * B;

  logic        clk = 1'b0;
  logic        resetn, frame_start, line_start, draw;
  logic [23:0] time_bcd;
  logic [3:0]  glyph_sel, bit_index;
  logic        pixel_valid, busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [23:0] m_shadow;
  int          m_line;
  bit          m_seen;
  logic [3:0]  m_glyph, m_bit;

  clock_display_sequencer #(.BOX_SIZE(B), .START_ROW(START)) dut (
    .pixelclock (clk),
    .resetn     (resetn),
    .frame_start(frame_start),
    .line_start (line_start),
    .draw       (draw),
    .time_bcd   (time_bcd),
    .glyph_sel  (glyph_sel),
    .bit_index  (bit_index),
    .pixel_valid(pixel_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected glyph of character position ch ("HH:MM:SS") for time t
  function automatic logic [3:0] exp_glyph(input int ch, input logic [23:0] t);
    int pos;
    logic [23:0] sh;
    if (ch == 2 || ch == 5) return 4'd10;
    pos = (ch < 2) ? 5 - ch : (ch < 5) ? 6 - ch : 7 - ch;
    sh = t >> (4 * pos);
    return (sh[3:0] > 4'd9) ? 4'd15 : sh[3:0];
  endfunction

  function automatic logic [23:0] rand_bcd(input bit allow_bad);
    logic [23:0] t;
    for (int i = 0; i < 6; i++) begin
      if (allow_bad && $urandom_range(0, 3) == 0) t[i*4 +: 4] = 4'($urandom_range(10, 15));
      else t[i*4 +: 4] = 4'($urandom_range(0, 9));
    end
    return t;
  endfunction

  task automatic do_frame(input logic [23:0] t);
    time_bcd = t;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    m_shadow = t;
    m_line = 0;
    m_seen = 1'b1;
  endtask

  task automatic pulse_lines(input int n);
    for (int i = 0; i < n; i++) begin
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      tick();
      if (m_line < 1023) m_line++;
    end
  endtask

  // One line: line_start, pre blank cycles, a draw window of len cycles, 3 tail cycles
  task automatic scan_line(input int len, input int pre, input string tag);
    bit inband;
    int row, lim_pix, lim_busy, ch, col;
    logic [3:0] g;
    logic ev, eb;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    if (m_line < 1023) m_line++;
    inband   = m_seen && (m_line >= START) && (m_line <= START + 5 * B - 1);
    row      = (m_line - START) / B;
    lim_pix  = inband ? ((len < SCAN_W) ? len : SCAN_W) : 0;
    lim_busy = inband ? ((len < SCAN_W - 1) ? len : SCAN_W - 1) : 0;
    for (int k = -pre; k < len + 3; k++) begin
      draw = (k >= 0) && (k < len);
      tick();
      ev = 1'b0;
      eb = (k >= 0) && (k < lim_busy);
      if (k >= 0 && k < lim_pix) begin
        ch  = k / (4 * B);
        col = (k / B) % 4;
        g   = exp_glyph(ch, m_shadow);
        if (col < 3 && g != 4'd15) begin
          ev = 1'b1;
          m_glyph = g;
          m_bit = 4'(row * 3 + col);
        end
      end
      checks += 4;
      if (pixel_valid !== ev) begin
        errors++;
        $display("FAIL %s line=%0d px=%0d pixel_valid got %b want %b", tag, m_line, k, pixel_valid, ev);
      end
      if (busy !== eb) begin
        errors++;
        $display("FAIL %s line=%0d px=%0d busy got %b want %b", tag, m_line, k, busy, eb);
      end
      if (glyph_sel !== m_glyph) begin
        errors++;
        $display("FAIL %s line=%0d px=%0d glyph_sel got %0d want %0d", tag, m_line, k, glyph_sel, m_glyph);
      end
      if (bit_index !== m_bit) begin
        errors++;
        $display("FAIL %s line=%0d px=%0d bit_index got %0d want %0d", tag, m_line, k, bit_index, m_bit);
      end
    end
    draw = 1'b0;
  endtask

  task automatic model_reset();
    m_shadow = '0;
    m_line = 0;
    m_seen = 1'b0;
    m_glyph = '0;
    m_bit = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    model_reset();
    checks += 4;
    if (glyph_sel !== 4'd0) begin errors++; $display("FAIL reset glyph_sel got %0d want 0", glyph_sel); end
    if (bit_index !== 4'd0) begin errors++; $display("FAIL reset bit_index got %0d want 0", bit_index); end
    if (pixel_valid !== 1'b0) begin errors++; $display("FAIL reset pixel_valid got %b want 0", pixel_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
    resetn = 1'b1;
    // Without a frame_start, reaching the band line count must not arm the scan
    for (int i = 0; i < START + 2; i++) scan_line(40, 1, "no_frame_after_reset");
  endtask

  task automatic test_basic();
    do_frame(24'h123456);
    pulse_lines(START - 1);
    scan_line(400, 2, "basic_123456");
  endtask

  task automatic test_rows();
    // Lines START+1 .. START+50; the last one is just past the band
    for (int i = 0; i < 5 * B; i++) scan_line(SCAN_W + 2, $urandom_range(0, 4), "row_walk");
  endtask

  task automatic test_mid_frame();
    do_frame(24'h000000);
    pulse_lines(START - 1);
    for (int i = 0; i < 6; i++) begin
      time_bcd = (i % 2 == 0) ? 24'h235959 : rand_bcd(1'b0);
      scan_line(SCAN_W, 1, "mid_frame_hold");
    end
    do_frame(24'h235959);
    pulse_lines(START - 1);
    scan_line(SCAN_W, 1, "new_frame_time");
  endtask

  task automatic test_invalid_digit();
    logic [23:0] t;
    t = rand_bcd(1'b0);
    t[23:20] = 4'hA;
    do_frame(t);
    pulse_lines(START - 1);
    scan_line(SCAN_W, 3, "invalid_hh");
    scan_line(SCAN_W, 0, "invalid_hh_line2");
  endtask

  task automatic test_abort();
    do_frame(rand_bcd(1'b0));
    pulse_lines(START - 1);
    scan_line(100, 2, "abort_100");
    scan_line(SCAN_W, 2, "after_abort");
    for (int i = 0; i < 5; i++) scan_line($urandom_range(1, SCAN_W + 10), $urandom_range(0, 3), "random_window");
  endtask

  task automatic test_frame_line_collide();
    time_bcd = rand_bcd(1'b1);
    frame_start = 1'b1;
    line_start = 1'b1;
    tick();
    frame_start = 1'b0;
    line_start = 1'b0;
    m_shadow = time_bcd;
    m_line = 0;
    m_seen = 1'b1;
    pulse_lines(START - 2);
    scan_line(60, 1, "collide_line_before_band");
    scan_line(SCAN_W, 1, "collide_band_first");
  endtask

  task automatic test_reset_mid_scan();
    do_frame(rand_bcd(1'b0));
    pulse_lines(START - 1);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    draw = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    resetn = 1'b0;
    tick();
    model_reset();
    checks += 4;
    if (glyph_sel !== 4'd0) begin errors++; $display("FAIL rst_scan glyph_sel got %0d want 0", glyph_sel); end
    if (bit_index !== 4'd0) begin errors++; $display("FAIL rst_scan bit_index got %0d want 0", bit_index); end
    if (pixel_valid !== 1'b0) begin errors++; $display("FAIL rst_scan pixel_valid got %b want 0", pixel_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_scan busy got %b want 0", busy); end
    draw = 1'b0;
    resetn = 1'b1;
    for (int i = 0; i < START + 2; i++) scan_line(40, 1, "rst_scan_no_resume");
    do_frame(rand_bcd(1'b0));
    pulse_lines(START - 1);
    scan_line(SCAN_W, 1, "rst_scan_resume");
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 3; f++) begin
      do_frame(rand_bcd(1'b1));
      pulse_lines($urandom_range(START - 4, START - 1));
      for (int i = 0; i < 8; i++) begin
        time_bcd = rand_bcd(1'b1);
        scan_line($urandom_range(SCAN_W - 40, SCAN_W + 20), $urandom_range(0, 5), "random_frame");
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    frame_start = 1'b0;
    line_start = 1'b0;
    draw = 1'b0;
    time_bcd = '0;
    model_reset();
    test_reset();
    test_basic();
    test_rows();
    test_mid_frame();
    test_invalid_digit();
    test_abort();
    test_frame_line_collide();
    test_reset_mid_scan();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
